// File: rtl/sd_regfile_if.sv
// Software access bus for sd_regfile: write/read strobes, address, data and byte enables
// from the master, and a one-cycle registered read response and error pulse from the slave.
interface sd_regfile_if #(
   parameter int unsigned AW = 4
);
   logic          wr_en;
   logic          rd_en;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic [3:0]    be;
   logic [31:0]   rdata;
   logic          rvalid;
   logic          err;

   modport master (
      output wr_en, rd_en, addr, wdata, be,
      input  rdata, rvalid, err
   );

   modport slave (
      input  wr_en, rd_en, addr, wdata, be,
      output rdata, rvalid, err
   );
endinterface

// File: rtl/sd_regfile.sv
// Register file with per-bit RW / RO / W1C / auto-clear behaviour, hardware load and set ports.
// Define SD_REGFILE_IRQ_EN to build the registered interrupt output; otherwise irq is tied low.
module sd_regfile #(
   parameter int unsigned           NUM_REGS     = 16,
   parameter int unsigned           AW           = 4,
   parameter logic [32*NUM_REGS-1:0] RESET_VAL   = '0,
   parameter logic [32*NUM_REGS-1:0] RW_MASK     = '1,
   parameter logic [32*NUM_REGS-1:0] W1C_MASK    = '0,
   parameter logic [32*NUM_REGS-1:0] AC_MASK     = '0,
   parameter int unsigned           IRQ_STAT_IDX = 12,
   parameter int unsigned           IRQ_EN_IDX   = 13
) (
   input  logic                   clk,
   input  logic                   reset,
   sd_regfile_if.slave            bus,
   input  logic [NUM_REGS-1:0]    hw_we,
   input  logic [32*NUM_REGS-1:0] hw_wdata,
   input  logic [32*NUM_REGS-1:0] hw_set,
   output logic [32*NUM_REGS-1:0] regs_out,
   output logic                   irq
);
   // W1C takes precedence over RW; auto-clear only applies to genuine RW bits.
   localparam logic [32*NUM_REGS-1:0] W1C_BITS = W1C_MASK;
   localparam logic [32*NUM_REGS-1:0] RW_BITS  = RW_MASK & ~W1C_MASK;
   localparam logic [32*NUM_REGS-1:0] AC_BITS  = AC_MASK & RW_BITS;

   logic [32*NUM_REGS-1:0] regs_q;
   logic [32*NUM_REGS-1:0] regs_d;
   logic [NUM_REGS-1:0]    sw_sel;
   logic [31:0]            byte_mask;
   logic [31:0]            rd_word;
   logic [31:0]            rdata_q;
   logic                   rvalid_q;
   logic                   err_q;
   logic                   in_range;

   assign in_range  = int'(bus.addr[AW-1:0]) < int'(NUM_REGS);
   assign byte_mask = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};

   always_comb begin
      sw_sel = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         sw_sel[r] = bus.wr_en && (int'(bus.addr) == r);
      end
   end

   always_comb begin
      regs_d = regs_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         for (int b = 0; b < 32; b++) begin
            if (W1C_BITS[32*r+b]) begin
               regs_d[32*r+b] = hw_set[32*r+b] |
                                (regs_q[32*r+b] & ~(sw_sel[r] & byte_mask[b] & bus.wdata[b]));
            end else if (RW_BITS[32*r+b] && sw_sel[r] && byte_mask[b]) begin
               regs_d[32*r+b] = bus.wdata[b];
            end else if (hw_we[r]) begin
               regs_d[32*r+b] = hw_wdata[32*r+b];
            end else if (AC_BITS[32*r+b]) begin
               regs_d[32*r+b] = 1'b0;
            end
         end
      end
   end

   // Out-of-range addresses match no register, so the read word falls through to zero.
   always_comb begin
      rd_word = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (int'(bus.addr) == r) begin
            rd_word = regs_q[32*r +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q   <= RESET_VAL;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         regs_q   <= regs_d;
         rvalid_q <= bus.rd_en;
         err_q    <= (bus.rd_en | bus.wr_en) & ~in_range;
         if (bus.rd_en) begin
            rdata_q <= rd_word;
         end
      end
   end

   assign regs_out   = regs_q;
   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;
   assign bus.err    = err_q;

`ifdef SD_REGFILE_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |(regs_q[32*IRQ_STAT_IDX +: 32] & regs_q[32*IRQ_EN_IDX +: 32]);
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_sd_regfile.sv
// Self-checking bench for sd_regfile: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a word-level behavioural model.
module tb_sd_regfile;
   localparam int unsigned N  = 16;
   localparam int unsigned AW = 5;
`ifdef SD_REGFILE_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   // Words listed from register 15 down to register 0.
   localparam logic [32*N-1:0] RST_V = {
      32'h0000_0000, 32'h0000_F00F, 32'h0000_0000, 32'h0000_0000,
      32'h0BAD_CAFE, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
      32'h5A5A_A5A5, 32'h0000_0000, 32'h0F00_0000, 32'h0000_0000,
      32'hCAFE_F00D, 32'h1234_5678, 32'h0000_0000, 32'h0000_0A5A};
   localparam logic [32*N-1:0] RW_M = {
      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
      32'hFF00_FF00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
      32'h0000_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   localparam logic [32*N-1:0] W1C_M = {
      32'h0, 32'h0, 32'h0, 32'h0000_FFFF,
      32'h0, 32'h0, 32'h0, 32'h0,
      32'h0000_00F0, 32'h0, 32'h0, 32'h0,
      32'h0, 32'h0, 32'h0, 32'h0};
   localparam logic [32*N-1:0] AC_M = {
      32'h0, 32'h0, 32'h0, 32'h0,
      32'h0, 32'h0, 32'h0, 32'h0,
      32'h0000_FF00, 32'h0, 32'h0F0F_0000, 32'h0000_0001,
      32'h0, 32'h0, 32'h0, 32'h0};

   logic             clk;
   logic             reset;
   logic [N-1:0]     hw_we;
   logic [32*N-1:0]  hw_wdata;
   logic [32*N-1:0]  hw_set;
   logic [32*N-1:0]  regs_out;
   logic             irq;

   sd_regfile_if #(.AW(AW)) bus ();

   sd_regfile #(
      .NUM_REGS     (N),
      .AW           (AW),
      .RESET_VAL    (RST_V),
      .RW_MASK      (RW_M),
      .W1C_MASK     (W1C_M),
      .AC_MASK      (AC_M),
      .IRQ_STAT_IDX (12),
      .IRQ_EN_IDX   (13)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .hw_we    (hw_we),
      .hw_wdata (hw_wdata),
      .hw_set   (hw_set),
      .regs_out (regs_out),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word(input logic [32*N-1:0] v, input int r);
      return v[32*r +: 32];
   endfunction

   // Behavioural model: whole-word mask arithmetic, updated at each rising edge.
   logic [31:0] m_regs [N];
   logic [31:0] m_nxt  [N];
   logic [31:0] m_rdata;
   logic        m_rvalid, m_err, m_irq;
   bit          model_valid = 1'b0;
   bit          in_rng;
   logic [31:0] bmask, w1c, rw, ac, ro, sw, hv;

   always @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < N; r++) m_regs[r] = word(RST_V, r);
         m_rdata     = '0;
         m_rvalid    = 1'b0;
         m_err       = 1'b0;
         m_irq       = 1'b0;
         model_valid = 1'b1;
      end else if (model_valid) begin
         in_rng   = int'(bus.addr) < N;
         m_irq    = IRQ_ON && (|(m_regs[12] & m_regs[13]));
         m_rvalid = bus.rd_en;
         m_err    = (bus.rd_en || bus.wr_en) && !in_rng;
         if (bus.rd_en) m_rdata = in_rng ? m_regs[bus.addr[3:0]] : 32'h0;
         bmask = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
         for (int r = 0; r < N; r++) begin
            w1c = word(W1C_M, r);
            rw  = word(RW_M, r) & ~w1c;
            ac  = word(AC_M, r) & rw;
            ro  = ~(rw | w1c);
            sw  = (bus.wr_en && int'(bus.addr) == r) ? bmask : 32'h0;
            hv  = hw_we[r] ? word(hw_wdata, r) : m_regs[r];
            m_nxt[r] = (w1c & (word(hw_set, r) | (m_regs[r] & ~(sw & bus.wdata))))
                     | (rw & sw & bus.wdata)
                     | (rw & ~sw & (hw_we[r] ? word(hw_wdata, r) : (m_regs[r] & ~ac)))
                     | (ro & hv);
         end
         m_regs = m_nxt;
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         chk("rvalid", {31'b0, bus.rvalid}, {31'b0, m_rvalid});
         chk("err", {31'b0, bus.err}, {31'b0, m_err});
         chk("irq", {31'b0, irq}, {31'b0, m_irq});
         chk("rdata", bus.rdata, m_rdata);
         for (int r = 0; r < N; r++) begin
            chk($sformatf("reg%0d", r), regs_out[32*r +: 32], m_regs[r]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.addr  = '0;
      bus.wdata = '0;
      bus.be    = '0;
      hw_we     = '0;
      hw_wdata  = '0;
      hw_set    = '0;
   endtask

   task automatic wr(input int a, input logic [31:0] d, input logic [3:0] b);
      bus.wr_en = 1'b1;
      bus.addr  = AW'(a);
      bus.wdata = d;
      bus.be    = b;
   endtask

   task automatic rd(input int a);
      bus.rd_en = 1'b1;
      bus.addr  = AW'(a);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      step();
      step();
      chk("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
      chk("rst_err", {31'b0, bus.err}, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      for (int r = 0; r < N; r++) chk("rst_reg", regs_out[32*r +: 32], word(RST_V, r));
      reset = 1'b0;

      // Read register 0 after reset.
      rd(0);
      step();
      idle();
      chk("rd0_rvalid", {31'b0, bus.rvalid}, 32'h1);
      chk("rd0_rdata", bus.rdata, 32'h0000_0A5A);
      step();
      chk("rd0_rvalid_drop", {31'b0, bus.rvalid}, 32'h0);
      chk("rd0_rdata_hold", bus.rdata, 32'h0000_0A5A);

      // Byte-enabled write.
      wr(1, 32'hAABB_CCDD, 4'b0101);
      step();
      idle();
      chk("be_reg1", regs_out[63:32], 32'h00BB_00DD);
      rd(1);
      step();
      idle();
      chk("be_rdata", bus.rdata, 32'h00BB_00DD);

      // Same-address write and read returns the pre-write value.
      wr(1, 32'h1111_2222, 4'b1111);
      bus.rd_en = 1'b1;
      step();
      idle();
      chk("rw_same_old", bus.rdata, 32'h00BB_00DD);
      chk("rw_same_new", regs_out[63:32], 32'h1111_2222);

      // W1C: set wins over a simultaneous clear, then a lone clear takes effect.
      hw_set[12*32+3] = 1'b1;
      step();
      idle();
      chk("w1c_set", regs_out[12*32 +: 32], 32'h8);
      hw_set[12*32+3] = 1'b1;
      wr(12, 32'h8, 4'b1111);
      step();
      idle();
      chk("w1c_set_wins", regs_out[12*32 +: 32], 32'h8);
      wr(12, 32'h8, 4'b1111);
      step();
      idle();
      chk("w1c_clear", regs_out[12*32 +: 32], 32'h0);

      // Interrupt follows status & enable one cycle late.
      wr(13, 32'h8, 4'b1111);
      step();
      idle();
      hw_set[12*32+3] = 1'b1;
      step();
      idle();
      chk("irq_lag", {31'b0, irq}, 32'h0);
      step();
      chk("irq_up", {31'b0, irq}, {31'b0, IRQ_ON});
      wr(12, 32'h8, 4'b1111);
      step();
      idle();
      chk("irq_hold", {31'b0, irq}, {31'b0, IRQ_ON});
      step();
      chk("irq_down", {31'b0, irq}, 32'h0);

      // Auto-clear bit holds 1 for exactly one cycle.
      wr(4, 32'h1, 4'b1111);
      step();
      idle();
      chk("ac_one", regs_out[4*32 +: 32], 32'h1);
      step();
      chk("ac_zero", regs_out[4*32 +: 32], 32'h0);

      // Out-of-range read and write.
      rd(16);
      step();
      idle();
      chk("oor_rdata", bus.rdata, 32'h0);
      chk("oor_rvalid", {31'b0, bus.rvalid}, 32'h1);
      chk("oor_err", {31'b0, bus.err}, 32'h1);
      step();
      chk("oor_err_drop", {31'b0, bus.err}, 32'h0);
      wr(16, 32'hFFFF_FFFF, 4'b1111);
      step();
      idle();
      chk("oor_wr_err", {31'b0, bus.err}, 32'h1);
      chk("oor_wr_reg0", regs_out[31:0], 32'h0000_0A5A);

      // Reset discards reads, both coincident and one cycle later.
      rd(0);
      reset = 1'b1;
      step();
      idle();
      reset = 1'b0;
      chk("rst_rd_same", {31'b0, bus.rvalid}, 32'h0);
      rd(0);
      step();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_rd_next", {31'b0, bus.rvalid}, 32'h0);
      chk("rst_rd_rdata", bus.rdata, 32'h0);
      for (int r = 0; r < N; r++) chk("rst_rd_reg", regs_out[32*r +: 32], word(RST_V, r));

      // Randomized traffic checked by the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         bus.wr_en = ($urandom_range(0, 2) == 0);
         bus.rd_en = ($urandom_range(0, 2) == 0);
         bus.addr  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(16, 31))
                                                 : AW'($urandom_range(0, 15));
         bus.wdata = $urandom;
         bus.be    = 4'($urandom);
         hw_we     = N'($urandom & $urandom & $urandom);
         for (int r = 0; r < N; r++) begin
            hw_wdata[32*r +: 32] = $urandom;
            hw_set[32*r +: 32]   = $urandom & $urandom & $urandom & $urandom;
         end
         reset = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0;
      idle();
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sd_regfile.md
SD_REGFILE -- requirements
Module: sd_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers (2..64).
REQ-002 SHALL have parameter AW, default 4, word-address width, with 2**AW >= NUM_REGS.
REQ-003 SHALL have parameter RESET_VAL [32*NUM_REGS-1:0], default 0, per-register reset image with register i at bits [32i+31:32i].
REQ-004 SHALL have parameter RW_MASK [32*NUM_REGS-1:0], default all ones, marking software-writable bits.
REQ-005 SHALL have parameter W1C_MASK [32*NUM_REGS-1:0], default 0, marking write-1-to-clear status bits.
REQ-006 SHALL have parameter AC_MASK [32*NUM_REGS-1:0], default 0, marking auto-clear bits, which must be a subset of RW_MASK.
REQ-007 SHALL have parameters IRQ_STAT_IDX, default 12, and IRQ_EN_IDX, default 13, giving the interrupt status and enable register indices.
REQ-008 clk  in  1  sole clock; all logic is rising-edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 wr_en  in  1  software write strobe, one transfer per cycle.
REQ-011 rd_en  in  1  software read strobe.
REQ-012 addr  in  AW  word address for wr_en and rd_en.
REQ-013 wdata  in  32  write data.
REQ-014 be  in  4  byte enables for wdata; be[k] covers bits [8k+7:8k].
REQ-015 rdata  out  32  read data, valid when rvalid=1.
REQ-016 rvalid  out  1  one-cycle read-response pulse.
REQ-017 err  out  1  one-cycle pulse on an access to addr >= NUM_REGS.
REQ-018 hw_we  in  NUM_REGS  per-register hardware load strobe.
REQ-019 hw_wdata  in  32*NUM_REGS  hardware load data.
REQ-020 hw_set  in  32*NUM_REGS  hardware set pulses for W1C bits.
REQ-021 regs_out  out  32*NUM_REGS  current contents of all registers.
REQ-022 irq  out  1  registered interrupt request.

Function
REQ-023 SHALL classify every bit as exactly one class: W1C (W1C_MASK=1), RW (RW_MASK=1, W1C=0) or RO (both 0); an AC bit is an RW bit.
REQ-024 RW bit: a software write with the bit's byte enabled SHALL load wdata next edge; otherwise hw_we SHALL load hw_wdata; a software write SHALL win over a simultaneous hw_we.
REQ-025 RO bit: software writes SHALL be ignored; hw_we SHALL load hw_wdata.
REQ-026 W1C bit: next = hw_set | (cur & ~clr), where clr = wdata bit & byte enabled & wr_en to this address; a set SHALL win over a simultaneous clear; hw_we SHALL be ignored.
REQ-027 AC bit: once it holds 1 for one cycle, it SHALL return to 0 on the following edge unless rewritten 1 on that edge.
REQ-028 Read: rd_en at edge N SHALL give rdata=reg[addr] with rvalid=1 for cycle N+1 only; rdata SHALL hold its value while rvalid=0.
REQ-029 A simultaneous wr_en and rd_en to the same address SHALL return the pre-write value.
REQ-030 Out-of-range access: a write SHALL change nothing; a read SHALL return 0 with rvalid=1; err=1 SHALL appear in the cycle after the access.
REQ-031 regs_out SHALL reflect register state combinationally from the flops with no added latency.
REQ-032 irq SHALL equal the registered OR-reduce of (reg[IRQ_STAT_IDX] & reg[IRQ_EN_IDX]), one cycle behind the register update.

Reset
REQ-033 On reset=1 at an edge, every register SHALL load RESET_VAL, and rdata=0, rvalid=0, err=0, irq=0.
REQ-034 Reset SHALL take priority over all writes, sets and auto-clears, and SHALL discard any read in flight (no rvalid after reset).

Configuration
REQ-035 With macro SD_REGFILE_IRQ_EN defined, irq SHALL behave per REQ-032.
REQ-036 With SD_REGFILE_IRQ_EN undefined, irq SHALL be tied to 0, no irq flop SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-037 Reset, then read reg 0 with RESET_VAL[31:0]=32'h0000_0A5A -> rdata=32'h0000_0A5A, rvalid high for exactly 1 cycle.
REQ-038 Write reg 1 wdata=32'hAABB_CCDD, be=4'b0101 after reset 0 -> reg 1 reads 32'h00BB_00DD.
REQ-039 With reg 12 W1C and bit 3 set by hw_set, write 32'h8 at the same edge a hw_set pulse lands on bit 3 -> bit 3 stays 1; write 32'h8 on the next cycle alone -> bit 3 clears.
REQ-040 With SD_REGFILE_IRQ_EN defined, reg 13=32'h8 and hw_set bit 3 of reg 12 -> irq=1 one cycle after the status bit sets; W1C clear -> irq=0 one cycle later.
REQ-041 With AC bit 0 of reg 4, write 32'h1 -> bit reads 1 for exactly one cycle, then 0; read addr 16 with NUM_REGS=16 -> rdata=0, err=1, no register changes.
REQ-042 Assert reset in the cycle after rd_en -> rvalid stays 0 and all registers equal RESET_VAL.
